// File: rtl/ps2_pkg.sv
// Shared PS/2 set-2 definitions: prefix bytes, discard codes, key-word layout
// and parser state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam int KEY_W        = 10;
  localparam int KEY_EXT      = 9;
  localparam int KEY_BRK      = 8;
  localparam int KEY_CODE_MSB = 7;
  localparam int KEY_CODE_LSB = 0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_t;

  // Keyboard status/ack bytes that never form part of a key word.
  function automatic logic is_discard(input logic [7:0] b);
    case (b)
      8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/key_fifo_fwft.sv
// Generic first-word-fall-through FIFO with occupancy count; the head word is
// presented combinationally and reads zero while the FIFO is empty.
module key_fifo_fwft #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = rd_en && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // NOTE: storage carries no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 set-2 byte-stream parser feeding a FWFT key-word queue polled by the CPU.
// Prefix bytes are folded into {ext, brk, code} words; stale prefixes time out.
module ps2_key_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int TIMEOUT      = 2000000,
  parameter int FILTER_BREAK = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             key_rd,
  input  logic             clr_ovf,
  output logic [KEY_W-1:0] key_out,
  output logic             key_ready,
  output logic [AW:0]      key_count,
  output logic             overflow
);

  localparam int TW = $clog2(TIMEOUT);

  ps2_state_t    state;
  ps2_state_t    state_next;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          push;
  key_word_t     word;
  logic          fifo_empty;
  logic          fifo_full;

  assign timeout_hit = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT - 1));

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    word.ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
    word.brk   = (state == ST_BRK) || (state == ST_EXT_BRK);
    word.code  = byte_in;
    if (byte_valid) begin
      if (byte_in == PS2_EXT) begin
        state_next = ST_EXT;
      end else if (byte_in == PS2_BRK) begin
        state_next = word.ext ? ST_EXT_BRK : ST_BRK;
      end else if (is_discard(byte_in)) begin
        state_next = ST_IDLE;
      end else begin
        state_next = ST_IDLE;
        push       = !((FILTER_BREAK != 0) && word.brk);
      end
    end else if (timeout_hit) begin
      state_next = ST_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (byte_valid || timeout_hit || state == ST_IDLE) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Drop condition mirrors the FIFO: full and no pop to make room; set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && fifo_full && !key_rd) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  key_fifo_fwft #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (KEY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (word),
    .rd_en   (key_rd),
    .rd_data (key_out),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (key_count)
  );

  assign key_ready = !fifo_empty;

endmodule
